// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flip-flop drive controller.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/sr_pulse_timer.sv
// 8-bit loadable down-counter; holds at zero rather than wrapping.
module sr_pulse_timer
  import sr_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero,
  output logic [TIMER_W-1:0] o_cnt
);

  logic [TIMER_W-1:0] r_cnt;
  logic [TIMER_W-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_load) begin
      w_cnt_d = i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      w_cnt_d = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sr_drive_ctrl.sv
// Command-driven pulse generator for a downstream SR flip-flop, with
// optional q feedback checking and a completed-command counter.
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1,
  parameter int unsigned CHK_EN  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  output logic       done,
  output logic       err,
  output logic [7:0] cmd_cnt
);

  localparam logic [TIMER_W-1:0] PULSE_LD = TIMER_W'(PULSE_W - 1);
  localparam logic [TIMER_W-1:0] GAP_LD   = TIMER_W'(GAP_W - 1);

  state_e             r_state;
  state_e             w_state_d;
  logic               r_op;
  logic               w_op_d;
  logic               w_accept;
  logic               w_load;
  logic [TIMER_W-1:0] w_load_val;
  logic               w_dec;
  logic               w_zero;
  logic [TIMER_W-1:0] w_tcnt;
  logic               w_done_end;
  logic               w_done_d;
  logic               w_drive_d;
  logic               w_mismatch;

  logic               r_s;
  logic               r_r;
  logic               r_ready;
  logic               r_done;
  logic               r_err;
  logic [7:0]         r_cnt;

  sr_pulse_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero),
    .o_cnt      (w_tcnt)
  );

  always_comb begin
    w_state_d  = r_state;
    w_accept   = 1'b0;
    w_load     = 1'b0;
    w_load_val = PULSE_LD;
    w_dec      = 1'b0;
    w_done_end = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept   = 1'b1;
          w_load     = 1'b1;
          w_load_val = PULSE_LD;
          w_state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = GAP_LD;
          w_state_d  = GAP;
        end else begin
          w_dec = 1'b1;
        end
      end
      GAP: begin
        if (w_zero) begin
          w_done_end = 1'b1;
          w_state_d  = IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state itself.
  always_comb begin
    w_op_d     = w_accept ? cmd_op : r_op;
    w_drive_d  = (w_state_d == DRIVE);
    w_done_d   = ((r_state == DRIVE) && w_zero && (GAP_LD == '0)) ||
                 ((r_state == GAP) && (w_tcnt == TIMER_W'(1)));
    w_mismatch = (CHK_EN != 0) && w_done_end && (q_fb != r_op);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_CLR;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_op    <= w_op_d;
      r_s     <= w_drive_d && (w_op_d == OP_SET);
      r_r     <= w_drive_d && (w_op_d == OP_CLR);
      r_ready <= (w_state_d == IDLE);
      r_done  <= w_done_d;
      if (w_mismatch) begin
        r_err <= 1'b1;
      end
      if (w_done_end) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign s         = r_s;
  assign r         = r_r;
  assign cmd_ready = r_ready;
  assign done      = r_done;
  assign err       = r_err;
  assign cmd_cnt   = r_cnt;

  a_no_overlap: assert property (@(posedge clk) !(r_s && r_r));

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: three parameterisations share one stimulus stream
// and are each checked every cycle against a command-timeline model.
module tb_sr_drive_ctrl;

  localparam int PW0 = 2;
  localparam int GW0 = 1;
  localparam int CK0 = 1;
  localparam int PW1 = 1;
  localparam int GW1 = 1;
  localparam int CK1 = 0;
  localparam int PW2 = 3;
  localparam int GW2 = 2;
  localparam int CK2 = 1;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_op;
  logic       q_fb;

  logic [2:0] ready_w;
  logic [2:0] s_w;
  logic [2:0] r_w;
  logic [2:0] done_w;
  logic [2:0] err_w;
  logic [7:0] cnt_w [3];

  int pw [3];
  int gw [3];
  int ck [3];

  // Model: each instance is either idle or at position pos (1-based cycle
  // count since the accept edge) within its pulse+gap window.
  bit m_busy [3];
  int m_pos  [3];
  bit m_op   [3];
  int m_cnt  [3];
  bit m_err  [3];

  int n_checks;
  int n_pass;
  int edge_no;

  sr_drive_ctrl #(.PULSE_W(PW0), .GAP_W(GW0), .CHK_EN(CK0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(ready_w[0]),
    .s(s_w[0]), .r(r_w[0]), .q_fb(q_fb), .done(done_w[0]), .err(err_w[0]), .cmd_cnt(cnt_w[0])
  );

  sr_drive_ctrl #(.PULSE_W(PW1), .GAP_W(GW1), .CHK_EN(CK1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(ready_w[1]),
    .s(s_w[1]), .r(r_w[1]), .q_fb(q_fb), .done(done_w[1]), .err(err_w[1]), .cmd_cnt(cnt_w[1])
  );

  sr_drive_ctrl #(.PULSE_W(PW2), .GAP_W(GW2), .CHK_EN(CK2)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(ready_w[2]),
    .s(s_w[2]), .r(r_w[2]), .q_fb(q_fb), .done(done_w[2]), .err(err_w[2]), .cmd_cnt(cnt_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
        m_pos[i]  = 0;
        m_op[i]   = 1'b0;
        m_cnt[i]  = 0;
        m_err[i]  = 1'b0;
      end else if (!m_busy[i]) begin
        if (cmd_valid) begin
          m_busy[i] = 1'b1;
          m_op[i]   = cmd_op;
          m_pos[i]  = 1;
        end
      end else if (m_pos[i] == pw[i] + gw[i]) begin
        if (ck[i] != 0 && q_fb != m_op[i]) m_err[i] = 1'b1;
        m_cnt[i]  = (m_cnt[i] + 1) % 256;
        m_busy[i] = 1'b0;
      end else begin
        m_pos[i]++;
      end
    end
  endtask

  task automatic compare_all();
    bit in_pulse;
    for (int i = 0; i < 3; i++) begin
      in_pulse = m_busy[i] && (m_pos[i] <= pw[i]);
      check($sformatf("u%0d.cmd_ready", i), 32'(ready_w[i]), 32'(!m_busy[i]));
      check($sformatf("u%0d.s", i), 32'(s_w[i]), 32'(in_pulse && m_op[i]));
      check($sformatf("u%0d.r", i), 32'(r_w[i]), 32'(in_pulse && !m_op[i]));
      check($sformatf("u%0d.s_and_r", i), 32'(s_w[i] & r_w[i]), 32'd0);
      check($sformatf("u%0d.done", i), 32'(done_w[i]),
            32'(m_busy[i] && (m_pos[i] == pw[i] + gw[i])));
      check($sformatf("u%0d.err", i), 32'(err_w[i]), 32'(m_err[i]));
      check($sformatf("u%0d.cmd_cnt", i), 32'(cnt_w[i]), 32'(m_cnt[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_no++;
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    cmd_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic send(input bit op, input bit fb);
    cmd_valid = 1'b1;
    cmd_op    = op;
    q_fb      = fb;
    cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int last_acc;
    n_checks  = 0;
    n_pass    = 0;
    edge_no   = 0;
    pw        = '{PW0, PW1, PW2};
    gw        = '{GW0, GW1, GW2};
    ck        = '{CK0, CK1, CK2};
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    q_fb      = 1'b0;
    #1;
    cycle();
    cycle();

    // Reset takes priority over a simultaneous request.
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    cycle();
    rst = 1'b0;

    // Good SET followed by idle time.
    send(1'b1, 1'b1);
    idle_cycles(6);

    // CLEAR with q stuck high: err sets and survives a good SET.
    send(1'b0, 1'b1);
    idle_cycles(6);
    send(1'b1, 1'b1);
    idle_cycles(6);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle_cycles(2);

    // Reset in the second DRIVE cycle aborts the command.
    send(1'b1, 1'b1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle_cycles(4);

    // Valid held with op toggling; accepts must be evenly spaced.
    last_acc  = -1;
    cmd_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cmd_op = k[0];
      if (ready_w[0]) begin
        if (last_acc >= 0) check("accept_spacing", 32'(edge_no + 1 - last_acc),
                                 32'(PW0 + GW0 + 1));
        last_acc = edge_no + 1;
      end
      cycle();
    end
    idle_cycles(8);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 39) == 0);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 1'($urandom_range(0, 1));
      q_fb      = 1'($urandom_range(0, 1));
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Back-to-back commands long enough to wrap every counter.
    cmd_valid = 1'b1;
    for (int k = 0; k < 1600; k++) begin
      cmd_op = 1'($urandom_range(0, 1));
      q_fb   = ($urandom_range(0, 7) == 0) ? ~cmd_op : cmd_op;
      cycle();
    end
    idle_cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter: PULSE_W, default 2, number of cycles s or r is held high per command; legal range 1..255.
REQ-002 Parameter: GAP_W, default 1, number of cycles with s=r=0 after each pulse; legal range 1..255.
REQ-003 Parameter: CHK_EN, default 1, enables q_fb checking.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: cmd_valid  input  1  command request.
REQ-007 Port: cmd_op  input  1  1 = SET, 0 = CLEAR; qualified by cmd_valid.
REQ-008 Port: cmd_ready  output  1  command accepted on an edge where cmd_valid and cmd_ready are both high.
REQ-009 Port: s  output  1  set drive to the downstream SR flip-flop.
REQ-010 Port: r  output  1  reset drive to the downstream SR flip-flop.
REQ-011 Port: q_fb  input  1  q fed back from the downstream SR flip-flop.
REQ-012 Port: done  output  1  one-cycle pulse marking the end of a command.
REQ-013 Port: err  output  1  sticky flag for a q_fb mismatch.
REQ-014 Port: cmd_cnt  output  8  count of completed commands.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DRIVE, GAP.
REQ-016 IDLE: cmd_ready=1, s=r=0; on accept, the state SHALL go to DRIVE, cmd_op SHALL be latched into op_q, and the timer SHALL load PULSE_W-1.
REQ-017 DRIVE: s=op_q and r=~op_q, cmd_ready=0; when the timer reaches 0, the state SHALL go to GAP with the timer loaded to GAP_W-1; otherwise the timer SHALL decrement.
REQ-018 GAP: s=r=0, cmd_ready=0; when the timer reaches 0, done=1 for that cycle and the state SHALL go to IDLE at the next edge; otherwise the timer SHALL decrement.
REQ-019 Latency: for an accept at edge k, s/r SHALL be high in cycles k+1..k+PULSE_W, the gap SHALL occupy cycles k+PULSE_W+1..k+PULSE_W+GAP_W, done SHALL be high in the last gap cycle, and cmd_ready SHALL be high again in the following cycle.
REQ-020 Throughput SHALL be one command per PULSE_W+GAP_W+1 cycles; the block SHALL NOT buffer commands.
REQ-021 s, r, cmd_ready, done, err and cmd_cnt SHALL all be registered outputs.
REQ-022 s and r SHALL never be high in the same cycle, under any input sequence including reset.
REQ-023 cmd_op and cmd_valid SHALL be ignored whenever cmd_ready=0; any change to them during DRIVE or GAP SHALL have no effect.
REQ-024 On the edge ending the done cycle, when CHK_EN=1, the block SHALL compare q_fb with op_q; on a mismatch, err SHALL be set to 1 on that edge.
REQ-025 err SHALL be cleared only by rst.
REQ-026 When CHK_EN=0, err SHALL remain 0.
REQ-027 cmd_cnt SHALL increment on the same edge as the done cycle ends, and SHALL wrap from 255 to 0 with no flag.
REQ-028 A redundant command (q_fb already equal to cmd_op) SHALL still execute the full pulse, gap and count sequence.

Reset
REQ-029 With rst=1 at an edge, state SHALL become IDLE; s=0, r=0, done=0, err=0, cmd_cnt=0, timer=0, op_q=0, and cmd_ready=1 from the next cycle.
REQ-030 Reset SHALL take priority over a simultaneous accept; no command SHALL be latched.
REQ-031 Reset asserted during DRIVE or GAP SHALL abort the command: s/r drop at that edge, with no done pulse and no cmd_cnt increment.

Structure
REQ-032 Package sr_pkg SHALL hold the state enumeration (IDLE, DRIVE, GAP) and the op constants OP_SET=1 and OP_CLR=0.
REQ-033 The timer SHALL be a sub-module sr_pulse_timer: 8-bit loadable down-counter with load, load value and dec inputs and a zero output.
REQ-034 The timer SHALL have the same clock and reset as the parent block.

Verification
REQ-035 PULSE_W=2, GAP_W=1; SET accepted at edge 0 with q_fb=1 from cycle 2 -> s=1 in cycles 1-2; r=0 throughout; done=1 in cycle 3; cmd_ready=1 in cycle 4; err=0; cmd_cnt=1.
REQ-036 CLEAR with q_fb stuck at 1 -> r=1 for PULSE_W cycles; err=1 after the done cycle; err stays 1 through a following good SET; err returns to 0 only after rst.
REQ-037 cmd_valid held high with cmd_op toggling every cycle for 20 cycles -> s&&r never high; each accepted command is spaced exactly PULSE_W+GAP_W+1 cycles apart.
REQ-038 rst asserted in the 2nd DRIVE cycle of a SET -> s=0 from that edge; no done pulse; cmd_cnt unchanged; cmd_ready=1 in the next cycle.
REQ-039 256 back-to-back commands -> cmd_cnt goes 255 to 0 on the 256th done.
REQ-040 PULSE_W=1, GAP_W=1, CHK_EN=0 with q_fb held wrong -> single-cycle s/r pulses; done every 3rd cycle; err stays 0.
